// File: rtl/grid_game.sv
// Grid adventure game core: walls, sword, dragon, exit, lives and a move budget.
// All game state is registered; the player moves at most one cell per clock.
module grid_game #(
    parameter int COLS = 4,
    parameter int ROWS = 4,
    parameter logic [ROWS*COLS-1:0] WALL_MASK = '0,
    parameter int START_X = 0,
    parameter int START_Y = 0,
    parameter int SWORD_X = 3,
    parameter int SWORD_Y = 0,
    parameter int DRAGON_X = 3,
    parameter int DRAGON_Y = 3,
    parameter int EXIT_X = 0,
    parameter int EXIT_Y = 3,
    parameter int LIVES = 3,
    parameter int MAX_MOVES = 32,
    localparam int XW = ($clog2(COLS) > 1) ? $clog2(COLS) : 1,
    localparam int YW = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1,
    localparam int LW = $clog2(LIVES + 1),
    localparam int MW = ($clog2(MAX_MOVES + 1) > 1) ? $clog2(MAX_MOVES + 1) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          n,
    input  logic          s,
    input  logic          e,
    input  logic          w,
    output logic [XW-1:0] pos_x,
    output logic [YW-1:0] pos_y,
    output logic          sword,
    output logic          dragon_alive,
    output logic [LW-1:0] lives,
    output logic [MW-1:0] moves,
    output logic          d,
    output logic          win
);

    localparam int NC = ROWS * COLS;
    localparam int IW = $clog2(NC);
    localparam int NP = 1 << IW;
    localparam logic [MW-1:0] MOVE_CAP =
        (MAX_MOVES != 0) ? MW'(MAX_MOVES) : {MW{1'b1}};

    function automatic bit bad_cell(int x, int y);
        logic [NC-1:0] v;
        if (x < 0 || x >= COLS || y < 0 || y >= ROWS) return 1'b1;
        v = WALL_MASK >> (y * COLS + x);
        return v[0];
    endfunction

    if (COLS < 2 || ROWS < 2 || LIVES < 1) begin : g_bad_dims
        $fatal(1, "grid_game: bad grid size or lives");
    end
    if (bad_cell(START_X, START_Y)) begin : g_bad_start
        $fatal(1, "grid_game: start cell off-grid or wall");
    end
    if (bad_cell(SWORD_X, SWORD_Y)) begin : g_bad_sword
        $fatal(1, "grid_game: sword cell off-grid or wall");
    end
    if (bad_cell(DRAGON_X, DRAGON_Y)) begin : g_bad_dragon
        $fatal(1, "grid_game: dragon cell off-grid or wall");
    end
    if (bad_cell(EXIT_X, EXIT_Y)) begin : g_bad_exit
        $fatal(1, "grid_game: exit cell off-grid or wall");
    end

    typedef enum logic [1:0] {PLAY, DEAD, WON} state_t;

    state_t        state, state_nx;
    logic [XW-1:0] pos_x_nx;
    logic [YW-1:0] pos_y_nx;
    logic          sword_nx, alive_nx;
    logic [LW-1:0] lives_nx;
    logic [MW-1:0] moves_nx;

    logic          single, edge_blk, wall_blk, blocked;
    logic          at_dragon, at_sword, at_exit;
    logic          hit, died, won;
    logic [XW-1:0] tx;
    logic [YW-1:0] ty;
    logic [IW-1:0] idx;
    logic [NP-1:0] walls;

    assign single = $countones({n, s, e, w}) == 1;
    assign tx = pos_x + XW'(e) - XW'(w);
    assign ty = pos_y + YW'(s) - YW'(n);
    assign edge_blk = (n && pos_y == '0)
                   || (s && pos_y == YW'(ROWS - 1))
                   || (e && pos_x == XW'(COLS - 1))
                   || (w && pos_x == '0);
    // Zero padding keeps the index in range even when a blocked move wraps.
    assign walls = NP'(WALL_MASK);
    assign idx = IW'(ty) * IW'(COLS) + IW'(tx);
    assign wall_blk = walls[idx];
    assign blocked = edge_blk || wall_blk;

    assign at_dragon = (tx == XW'(DRAGON_X)) && (ty == YW'(DRAGON_Y));
    assign at_sword = (tx == XW'(SWORD_X)) && (ty == YW'(SWORD_Y));
    assign at_exit = (tx == XW'(EXIT_X)) && (ty == YW'(EXIT_Y));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= PLAY;
            pos_x        <= XW'(START_X);
            pos_y        <= YW'(START_Y);
            sword        <= 1'b0;
            dragon_alive <= 1'b1;
            lives        <= LW'(LIVES);
            moves        <= '0;
        end else begin
            state        <= state_nx;
            pos_x        <= pos_x_nx;
            pos_y        <= pos_y_nx;
            sword        <= sword_nx;
            dragon_alive <= alive_nx;
            lives        <= lives_nx;
            moves        <= moves_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pos_x_nx = pos_x;
        pos_y_nx = pos_y;
        sword_nx = sword;
        alive_nx = dragon_alive;
        lives_nx = lives;
        moves_nx = moves;
        hit      = 1'b0;
        died     = 1'b0;
        won      = 1'b0;
        if (state == PLAY && single) begin
            if (moves != MOVE_CAP) moves_nx = moves + 1'b1;
            if (!blocked) begin
                pos_x_nx = tx;
                pos_y_nx = ty;
                if (at_dragon && dragon_alive) begin
                    if (sword) begin
                        alive_nx = 1'b0;
                    end else begin
                        hit      = 1'b1;
                        lives_nx = lives - 1'b1;
                        if (lives == LW'(1)) begin
                            died = 1'b1;
                        end else begin
                            pos_x_nx = XW'(START_X);
                            pos_y_nx = YW'(START_Y);
                        end
                    end
                end
                // A player knocked back to spawn never reached the cell.
                if (!hit) begin
                    if (at_sword) sword_nx = 1'b1;
                    if (at_exit && !alive_nx) won = 1'b1;
                end
            end
            if (MAX_MOVES != 0 && moves_nx == MOVE_CAP) died = 1'b1;
            if (won) state_nx = WON;
            else if (died) state_nx = DEAD;
        end
    end

    always_comb begin
        d   = (state == DEAD);
        win = (state == WON);
    end

endmodule

// File: tb/tb_grid_game.sv
// Bench for grid_game: three instances (default, one wall, 9-move budget)
// checked every cycle against a cell-level game model plus literal checks.
module tb_grid_game;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic n = 1'b0, s = 1'b0, e = 1'b0, w = 1'b0;
    bit   run = 1'b1;

    initial forever begin
        #5;
        if (run) clk = ~clk;
    end

    logic [1:0] a_x, a_y, b_x, b_y, c_x, c_y;
    logic [1:0] a_l, b_l, c_l;
    logic [5:0] a_m, b_m;
    logic [3:0] c_m;
    logic a_sw, a_al, a_d, a_w;
    logic b_sw, b_al, b_d, b_w;
    logic c_sw, c_al, c_d, c_w;

    grid_game dut_a (
        .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
        .pos_x(a_x), .pos_y(a_y), .sword(a_sw), .dragon_alive(a_al),
        .lives(a_l), .moves(a_m), .d(a_d), .win(a_w)
    );

    grid_game #(.WALL_MASK(16'h0002)) dut_b (
        .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
        .pos_x(b_x), .pos_y(b_y), .sword(b_sw), .dragon_alive(b_al),
        .lives(b_l), .moves(b_m), .d(b_d), .win(b_w)
    );

    grid_game #(.MAX_MOVES(9)) dut_c (
        .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
        .pos_x(c_x), .pos_y(c_y), .sword(c_sw), .dragon_alive(c_al),
        .lives(c_l), .moves(c_m), .d(c_d), .win(c_w)
    );

    typedef struct {
        int x, y, lives, moves;
        bit sword, alive, dead, won;
    } st_t;

    st_t ma, mb, mc;
    int checks = 0;
    int errors = 0;

    function automatic st_t init_st();
        st_t m;
        m.x = 0; m.y = 0; m.lives = 3; m.moves = 0;
        m.sword = 0; m.alive = 1; m.dead = 0; m.won = 0;
        return m;
    endfunction

    // Game rules on a 4x4 map: sword (3,0), dragon (3,3), exit (0,3).
    function automatic st_t step(st_t m, logic [15:0] walls, int maxm);
        int tx, ty;
        bit hit;
        if (m.dead || m.won) return m;
        if (int'(n) + int'(s) + int'(e) + int'(w) != 1) return m;
        if (m.moves < maxm) m.moves++;
        tx = m.x + int'(e) - int'(w);
        ty = m.y + int'(s) - int'(n);
        hit = 0;
        if (tx >= 0 && tx < 4 && ty >= 0 && ty < 4 && !walls[ty*4+tx]) begin
            m.x = tx;
            m.y = ty;
            if (tx == 3 && ty == 3 && m.alive) begin
                if (m.sword) m.alive = 0;
                else begin
                    hit = 1;
                    m.lives--;
                    if (m.lives == 0) m.dead = 1;
                    else begin m.x = 0; m.y = 0; end
                end
            end
            if (!hit) begin
                if (tx == 3 && ty == 0) m.sword = 1;
                if (tx == 0 && ty == 3 && !m.alive) m.won = 1;
            end
        end
        if (!m.won && m.moves == maxm) m.dead = 1;
        if (m.won) m.dead = 0;
        return m;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ma <= init_st();
            mb <= init_st();
            mc <= init_st();
        end else begin
            ma <= step(ma, 16'h0000, 32);
            mb <= step(mb, 16'h0002, 32);
            mc <= step(mc, 16'h0000, 9);
        end
    end

    task automatic cmp(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_st(string tag, st_t m, int x, int y, int sw, int al,
                          int lv, int mv, int dd, int wn);
        cmp({tag, ".pos_x"}, x, m.x);
        cmp({tag, ".pos_y"}, y, m.y);
        cmp({tag, ".sword"}, sw, int'(m.sword));
        cmp({tag, ".dragon_alive"}, al, int'(m.alive));
        cmp({tag, ".lives"}, lv, m.lives);
        cmp({tag, ".moves"}, mv, m.moves);
        cmp({tag, ".d"}, dd, int'(m.dead));
        cmp({tag, ".win"}, wn, int'(m.won));
    endtask

    always @(negedge clk) begin
        cmp_st("a", ma, int'(a_x), int'(a_y), int'(a_sw), int'(a_al),
               int'(a_l), int'(a_m), int'(a_d), int'(a_w));
        cmp_st("b", mb, int'(b_x), int'(b_y), int'(b_sw), int'(b_al),
               int'(b_l), int'(b_m), int'(b_d), int'(b_w));
        cmp_st("c", mc, int'(c_x), int'(c_y), int'(c_sw), int'(c_al),
               int'(c_l), int'(c_m), int'(c_d), int'(c_w));
    end

    task automatic go(bit nn, bit ss, bit ee, bit ww, int k);
        n = nn; s = ss; e = ee; w = ww;
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n = 0; s = 0; e = 0; w = 0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #1;
        do_reset();
        // Reset state
        cmp("rst_pos_x", int'(a_x), 0);
        cmp("rst_pos_y", int'(a_y), 0);
        cmp("rst_lives", int'(a_l), 3);
        cmp("rst_moves", int'(a_m), 0);
        cmp("rst_sword", int'(a_sw), 0);
        cmp("rst_alive", int'(a_al), 1);
        cmp("rst_d_win", int'({a_d, a_w}), 0);
        go(0, 0, 1, 0, 2);
        cmp("mid_pos_x", int'(a_x), 2);
        // Asynchronous reset with the clock held low
        @(negedge clk);
        run = 1'b0;
        #2 reset = 1'b0;
        #1;
        cmp("async_pos_x", int'(a_x), 0);
        cmp("async_moves", int'(a_m), 0);
        cmp("async_lives", int'(a_l), 3);
        #2 reset = 1'b1;
        run = 1'b1;

        // Hold south into the exit and then the bottom wall until timeout
        do_reset();
        go(0, 1, 0, 0, 3);
        cmp("s3_pos_y", int'(a_y), 3);
        cmp("s3_win", int'(a_w), 0);
        go(0, 1, 0, 0, 28);
        cmp("s31_moves", int'(a_m), 31);
        cmp("s31_d", int'(a_d), 0);
        go(0, 1, 0, 0, 1);
        cmp("s32_moves", int'(a_m), 32);
        cmp("s32_d", int'(a_d), 1);
        go(1, 0, 1, 0, 2);
        go(0, 0, 0, 1, 2);
        cmp("dead_sticky", int'(a_d), 1);
        cmp("dead_pos_y", int'(a_y), 3);
        cmp("c_timeout_d", int'(c_d), 1);

        // Win path
        do_reset();
        go(0, 0, 1, 0, 3);
        cmp("win_sword", int'(a_sw), 1);
        cmp("win_moves3", int'(a_m), 3);
        go(0, 1, 0, 0, 3);
        cmp("win_slain", int'(a_al), 0);
        cmp("win_lives", int'(a_l), 3);
        go(0, 0, 0, 1, 3);
        cmp("win_pos_x", int'(a_x), 0);
        cmp("win_flag", int'(a_w), 1);
        cmp("win_moves9", int'(a_m), 9);
        cmp("win_d", int'(a_d), 0);
        cmp("c_win_beats_timeout", int'({c_w, c_d}), 2);
        go(1, 0, 0, 0, 2);
        cmp("win_frozen_y", int'(a_y), 3);

        // Death by dragon three times
        do_reset();
        go(0, 1, 0, 0, 3);
        go(0, 0, 1, 0, 3);
        cmp("hit1_lives", int'(a_l), 2);
        cmp("hit1_pos", int'({a_x, a_y}), 0);
        cmp("hit1_sword", int'(a_sw), 0);
        repeat (2) begin
            go(0, 1, 0, 0, 3);
            go(0, 0, 1, 0, 3);
        end
        cmp("hit3_lives", int'(a_l), 0);
        cmp("hit3_d", int'(a_d), 1);
        cmp("hit3_pos", int'({a_x, a_y}), 15);

        // Illegal input and walls on the walled instance
        do_reset();
        go(1, 0, 1, 0, 1);
        cmp("ne_moves", int'(b_m), 0);
        go(0, 0, 1, 0, 1);
        cmp("wall_pos_x", int'(b_x), 0);
        cmp("wall_moves", int'(b_m), 1);
        go(0, 0, 0, 1, 1);
        cmp("west_edge_moves", int'(b_m), 2);
        cmp("west_edge_pos_x", int'(b_x), 0);
        go(0, 0, 0, 0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
